mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles an access waits for dmem_ack before abort.
REQ-002 SHALL have port clk  in  1  all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have inputs from EX/MEM: in_valid 1; alu_res_in 32 (result/address); write_data_in 32 (store data); dst_reg_in 6; wb_ctrl_in 3; mem_ctrl_in 2 (bit0 read, bit1 write); pc_plus_imm_in 32.
REQ-005 SHALL have data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_ack in 1; dmem_rdata in 32.
REQ-006 SHALL have stall out 1: upstream holds EX/MEM contents while high.
REQ-007 SHALL have MEM/WB outputs, all registered: wb_valid 1; wb_alu_res 32; wb_mem_data 32; wb_dst_reg 6; wb_ctrl 3; wb_pc_plus_imm 32; mem_err 1.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS; stall = (state==ACCESS); dmem_req = (state==ACCESS).
REQ-009 In IDLE with in_valid=0 at an edge: wb_valid<=0, mem_err<=0, other wb_* outputs hold.
REQ-010 In IDLE, in_valid=1, mem_ctrl_in=00: wb_* <= inputs at same edge (1-cycle latency), wb_mem_data<=0, wb_valid<=1, mem_err<=0.
REQ-011 In IDLE, in_valid=1, mem_ctrl_in 01 or 10, alu_res_in[1:0]==00: latch all inputs internally, go ACCESS, clear timeout counter, wb_valid<=0.
REQ-012 In ACCESS: dmem_addr = latched address, dmem_we = latched write bit, dmem_wdata = latched store data, all constant until exit; in_valid and EX/MEM inputs ignored.
REQ-013 ACCESS, dmem_ack=1 at an edge: go IDLE; wb_* <= latched fields; wb_mem_data <= dmem_rdata for reads, 0 for writes; wb_valid<=1; mem_err<=0.
REQ-014 Zero-wait memory (ack on first ACCESS cycle) SHALL give 2-cycle total latency and 1 stall cycle.
REQ-015 ACCESS, no ack: counter increments per cycle; at the edge where counter==TIMEOUT-1 without ack: go IDLE, wb_valid<=1, wb_ctrl<=000 (write-back suppressed), wb_dst_reg<=latched, mem_err<=1 for one cycle.
REQ-016 Ack and timeout at same edge: ack wins (normal completion, mem_err=0).
REQ-017 IDLE, in_valid=1, mem_ctrl_in==11 or misaligned address with a memory op: no dmem_req; wb_valid<=1, wb_ctrl<=000, mem_err<=1 for one cycle, remaining in IDLE.
REQ-018 Late dmem_ack while IDLE SHALL be ignored.
REQ-019 Counter width SHALL hold TIMEOUT-1; TIMEOUT>=1 required.

Reset
REQ-020 rst=1 SHALL asynchronously force IDLE, counter 0, every wb_* output and mem_err to 0, stall/dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0.
REQ-021 rst asserted during ACCESS SHALL abandon the access with no write-back and no mem_err; post-reset first in_valid is handled as fresh.

Verification
REQ-022 ALU op: in_valid=1, mem_ctrl=00, alu_res=0x0000_0010, dst=5, wb_ctrl=101 -> next edge wb_valid=1, wb_alu_res=0x10, wb_dst_reg=5, wb_ctrl=101, stall never high.
REQ-023 Load with ack after 3 cycles: mem_ctrl=01, addr=0x100, dmem_rdata=0xDEADBEEF -> dmem_req high 3 cycles at addr 0x100, stall high 3 cycles, then wb_valid=1, wb_mem_data=0xDEADBEEF.
REQ-024 Store, zero-wait: mem_ctrl=10, addr=0x200, data=0x1234_5678, ack on first ACCESS cycle -> one cycle dmem_req with we=1, wdata=0x12345678; wb_valid=1, wb_mem_data=0.
REQ-025 Timeout: TIMEOUT=4, load, no ack -> dmem_req high exactly 4 cycles, then wb_valid=1, wb_ctrl=000, mem_err=1 for one cycle.
REQ-026 Illegal/misaligned: mem_ctrl=11, or mem_ctrl=01 with addr=0x102 -> no dmem_req; next edge mem_err=1, wb_ctrl=000.
REQ-027 rst pulse mid-ACCESS -> immediate dmem_req=0, stall=0, all outputs 0; following ALU op completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a single-outstanding data-memory handshake with timeout abort.
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] write_data_in,
  input  logic [5:0]  dst_reg_in,
  input  logic [2:0]  wb_ctrl_in,
  input  logic [1:0]  mem_ctrl_in,
  input  logic [31:0] pc_plus_imm_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_alu_res,
  output logic [31:0] wb_mem_data,
  output logic [5:0]  wb_dst_reg,
  output logic [2:0]  wb_ctrl,
  output logic [31:0] wb_pc_plus_imm,
  output logic        mem_err
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [5:0]  dst_q;
  logic [2:0]  ctrl_q;
  logic        we_q;
  logic        idle, pass, bad, start, ack_done, tmo;
  always_comb begin
    idle     = state == IDLE;
    pass     = idle && in_valid && mem_ctrl_in == 2'b00;
    bad      = idle && in_valid && mem_ctrl_in != 2'b00 && (mem_ctrl_in == 2'b11 || alu_res_in[1:0] != 2'b00);
    start    = idle && in_valid && mem_ctrl_in != 2'b00 && !bad;
    ack_done = !idle && dmem_ack;
    tmo      = !idle && !dmem_ack && cnt == CW'(TIMEOUT - 1);
    state_n  = start ? ACCESS : (ack_done || tmo) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  assign stall      = state == ACCESS;
  assign dmem_req   = stall;
  assign dmem_we    = stall & we_q;
  assign dmem_addr  = stall ? addr_q : '0;
  assign dmem_wdata = stall ? wdata_q : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      pc_q           <= '0;
      dst_q          <= '0;
      ctrl_q         <= '0;
      we_q           <= 1'b0;
      wb_valid       <= 1'b0;
      wb_alu_res     <= '0;
      wb_mem_data    <= '0;
      wb_dst_reg     <= '0;
      wb_ctrl        <= '0;
      wb_pc_plus_imm <= '0;
      mem_err        <= 1'b0;
    end else begin
      cnt      <= start ? '0 : stall ? cnt + CW'(1) : cnt;
      wb_valid <= pass | bad | ack_done | tmo;
      mem_err  <= bad | tmo;
      if (start) begin
        addr_q  <= alu_res_in;
        wdata_q <= write_data_in;
        pc_q    <= pc_plus_imm_in;
        dst_q   <= dst_reg_in;
        ctrl_q  <= wb_ctrl_in;
        we_q    <= mem_ctrl_in[1];
      end
      if (pass | bad) begin
        wb_alu_res     <= alu_res_in;
        wb_mem_data    <= '0;
        wb_dst_reg     <= dst_reg_in;
        wb_ctrl        <= pass ? wb_ctrl_in : 3'b000;
        wb_pc_plus_imm <= pc_plus_imm_in;
      end else if (ack_done | tmo) begin
        wb_alu_res     <= addr_q;
        wb_mem_data    <= (ack_done && !we_q) ? dmem_rdata : '0;
        wb_dst_reg     <= dst_q;
        wb_ctrl        <= ack_done ? ctrl_q : 3'b000;
        wb_pc_plus_imm <= pc_q;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus checked against a transaction-level model of the MEM stage.
module tb_mem_stage;
  localparam int TO = 4;
  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] alu_res_in = '0, write_data_in = '0, pc_plus_imm_in = '0;
  logic [5:0]  dst_reg_in = '0;
  logic [2:0]  wb_ctrl_in = '0;
  logic [1:0]  mem_ctrl_in = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0, stall, wb_valid, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [31:0] wb_alu_res, wb_mem_data, wb_pc_plus_imm;
  logic [5:0]  wb_dst_reg;
  logic [2:0]  wb_ctrl;
  int checks = 0, errors = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_res_in(alu_res_in),
    .write_data_in(write_data_in), .dst_reg_in(dst_reg_in), .wb_ctrl_in(wb_ctrl_in),
    .mem_ctrl_in(mem_ctrl_in), .pc_plus_imm_in(pc_plus_imm_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_alu_res(wb_alu_res), .wb_mem_data(wb_mem_data),
    .wb_dst_reg(wb_dst_reg), .wb_ctrl(wb_ctrl), .wb_pc_plus_imm(wb_pc_plus_imm), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr, wdata, pc;
    logic [5:0]  dst;
    logic [2:0]  ctrl;
    logic        write;
  } txn_t;
  txn_t t;
  bit busy = 0;
  int waited = 0;
  logic        e_valid = 0, e_err = 0, e_full = 0, e_dst_ok = 0;
  logic [31:0] e_alu = '0, e_md = '0, e_pc = '0;
  logic [5:0]  e_dst = '0;
  logic [2:0]  e_ctrl = '0;

  // Outstanding access counts cycles spent waiting; TO waiting cycles without ack aborts it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy = 0; e_valid = 0; e_err = 0; e_full = 0; e_dst_ok = 0;
      e_alu = '0; e_md = '0; e_pc = '0; e_dst = '0; e_ctrl = '0;
    end else if (busy) begin
      waited++;
      if (dmem_ack || waited == TO) begin
        busy = 0; e_valid = 1; e_err = !dmem_ack; e_full = dmem_ack; e_dst_ok = 1;
        e_dst = t.dst;
        e_ctrl = dmem_ack ? t.ctrl : 3'b000;
        e_alu = t.addr; e_pc = t.pc;
        e_md = (dmem_ack && !t.write) ? dmem_rdata : 32'h0;
      end else begin
        e_valid = 0; e_err = 0;
      end
    end else if (!in_valid) begin
      e_valid = 0; e_err = 0;
    end else if (mem_ctrl_in == 2'b00) begin
      e_valid = 1; e_err = 0; e_full = 1; e_dst_ok = 1;
      e_alu = alu_res_in; e_md = 0; e_dst = dst_reg_in; e_ctrl = wb_ctrl_in; e_pc = pc_plus_imm_in;
    end else if (mem_ctrl_in == 2'b11 || alu_res_in % 4 != 0) begin
      e_valid = 1; e_err = 1; e_full = 0; e_dst_ok = 0; e_ctrl = 3'b000;
    end else begin
      busy = 1; waited = 0; e_valid = 0; e_err = 0;
      t = '{alu_res_in, write_data_in, pc_plus_imm_in, dst_reg_in, wb_ctrl_in, mem_ctrl_in == 2'b10};
    end
  end

  always @(negedge clk) begin
    chk("stall", 32'(stall), 32'(busy));
    chk("dmem_req", 32'(dmem_req), 32'(busy));
    if (busy) begin
      chk("dmem_we", 32'(dmem_we), 32'(t.write));
      chk("dmem_addr", dmem_addr, t.addr);
      if (t.write) chk("dmem_wdata", dmem_wdata, t.wdata);
    end
    chk("wb_valid", 32'(wb_valid), 32'(e_valid));
    chk("mem_err", 32'(mem_err), 32'(e_err));
    if (e_valid) chk("wb_ctrl", 32'(wb_ctrl), 32'(e_ctrl));
    if (e_valid && e_dst_ok) chk("wb_dst_reg", 32'(wb_dst_reg), 32'(e_dst));
    if (e_valid && e_full) begin
      chk("wb_alu_res", wb_alu_res, e_alu);
      chk("wb_mem_data", wb_mem_data, e_md);
      chk("wb_pc_plus_imm", wb_pc_plus_imm, e_pc);
    end
  end

  task automatic drive(input logic [1:0] mc, input logic [31:0] a, input logic [31:0] wd,
                       input logic [5:0] d, input logic [2:0] c, input logic [31:0] pc);
    @(negedge clk); #1;
    in_valid = 1; mem_ctrl_in = mc; alu_res_in = a; write_data_in = wd;
    dst_reg_in = d; wb_ctrl_in = c; pc_plus_imm_in = pc;
  endtask

  // Issues the already-driven memory op, scrambles EX/MEM inputs during the access, acks on request cycle ack_at.
  task automatic mem_op(input int ack_at, input logic [31:0] exp_addr, output int reqs);
    reqs = 0;
    @(posedge clk); #1;
    mem_ctrl_in = 2'b00; alu_res_in = ~alu_res_in; dst_reg_in = ~dst_reg_in;
    for (int i = 0; i < 20; i++) begin
      if (!dmem_req) break;
      reqs++;
      if (reqs == 1) chk("req_addr", dmem_addr, exp_addr);
      dmem_ack = (reqs == ack_at);
      @(posedge clk); #1;
      dmem_ack = 0;
    end
    in_valid = 0;
  endtask

  int n;
  initial begin
    #2 rst = 1;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_wb_alu_res", wb_alu_res, 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    drive(2'b00, 32'h10, 32'h0, 6'd5, 3'b101, 32'h40);
    @(posedge clk); #1;
    in_valid = 0;
    chk("alu_valid", 32'(wb_valid), 32'd1);
    chk("alu_res", wb_alu_res, 32'h10);
    chk("alu_dst", 32'(wb_dst_reg), 32'd5);
    chk("alu_ctrl", 32'(wb_ctrl), 32'd5);
    chk("alu_stall", 32'(stall), 32'd0);
    drive(2'b00, 32'hCAFE_0003, 32'h0, 6'd63, 3'b010, 32'h8000_0000);
    @(posedge clk); #1;
    in_valid = 0;
    chk("alu2_res", wb_alu_res, 32'hCAFE_0003);
    dmem_rdata = 32'hDEAD_BEEF;
    drive(2'b01, 32'h100, 32'h0, 6'd7, 3'b011, 32'h104);
    mem_op(3, 32'h100, n);
    chk("load_req_cycles", 32'(n), 32'd3);
    chk("load_valid", 32'(wb_valid), 32'd1);
    chk("load_data", wb_mem_data, 32'hDEAD_BEEF);
    chk("load_dst", 32'(wb_dst_reg), 32'd7);
    drive(2'b10, 32'h200, 32'h1234_5678, 6'd9, 3'b001, 32'h208);
    @(posedge clk); #1;
    chk("store_we", 32'(dmem_we), 32'd1);
    chk("store_wdata", dmem_wdata, 32'h1234_5678);
    dmem_ack = 1;
    @(posedge clk); #1;
    dmem_ack = 0; in_valid = 0;
    chk("store_valid", 32'(wb_valid), 32'd1);
    chk("store_mem_data", wb_mem_data, 32'd0);
    chk("store_req_after", 32'(dmem_req), 32'd0);
    drive(2'b01, 32'h300, 32'h0, 6'd11, 3'b111, 32'h0);
    mem_op(0, 32'h300, n);
    chk("tmo_req_cycles", 32'(n), 32'd4);
    chk("tmo_err", 32'(mem_err), 32'd1);
    chk("tmo_ctrl", 32'(wb_ctrl), 32'd0);
    chk("tmo_dst", 32'(wb_dst_reg), 32'd11);
    @(posedge clk); #1;
    chk("tmo_err_one_cycle", 32'(mem_err), 32'd0);
    drive(2'b01, 32'h400, 32'h0, 6'd12, 3'b110, 32'h0);
    dmem_rdata = 32'h0BAD_F00D;
    mem_op(4, 32'h400, n);
    chk("ack_tmo_cycles", 32'(n), 32'd4);
    chk("ack_tmo_err", 32'(mem_err), 32'd0);
    chk("ack_tmo_data", wb_mem_data, 32'h0BAD_F00D);
    drive(2'b11, 32'h500, 32'h0, 6'd1, 3'b111, 32'h0);
    @(posedge clk); #1;
    chk("illegal_req", 32'(dmem_req), 32'd0);
    chk("illegal_err", 32'(mem_err), 32'd1);
    chk("illegal_ctrl", 32'(wb_ctrl), 32'd0);
    drive(2'b01, 32'h102, 32'h0, 6'd2, 3'b111, 32'h0);
    @(posedge clk); #1;
    in_valid = 0;
    chk("misalign_req", 32'(dmem_req), 32'd0);
    chk("misalign_err", 32'(mem_err), 32'd1);
    dmem_ack = 1;
    @(posedge clk); #1;
    dmem_ack = 0;
    chk("late_ack_valid", 32'(wb_valid), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    drive(2'b01, 32'h600, 32'h0, 6'd3, 3'b111, 32'h0);
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    #2 rst = 1;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_alu", wb_alu_res, 32'd0);
    @(negedge clk); #1;
    rst = 0;
    drive(2'b00, 32'h77, 32'h0, 6'd4, 3'b100, 32'h99);
    @(posedge clk); #1;
    in_valid = 0;
    chk("post_rst_valid", 32'(wb_valid), 32'd1);
    chk("post_rst_alu", wb_alu_res, 32'h77);
    chk("post_rst_err", 32'(mem_err), 32'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
endmodule
